ysyx_041514_pc_gen: RTL and testbench
=====================================

# ysyx_041514_pc_gen

Fetch-address generator for the pipeline front end: holds the architectural fetch PC, issues one fetch request per cycle to the icache through a valid/ready handshake, and selects the next PC from trap, fence.i, branch-redirect and sequential/predicted sources. It is parametrised in PC width, fetch-address width and reset vector. It adds an optional direct-mapped branch target buffer (BTB) with 2-bit saturating counters, trained by the execute stage. It sits between the pipeline controller and the icache, and feeds the IF stage.

## Interface
- XLEN, 64, architectural PC width
- ADDR_W, 32, icache fetch-address width (ADDR_W <= XLEN)
- RESET_ADDR, 64'h8000_0000, PC value at reset
- BTB_ENTRIES, 8, BTB depth; power of two, >= 2
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- stall_i  in  1  hold PC; no new request
- trap_valid_i / trap_pc_i  in  1 / XLEN  trap or mret target, from mem
- fencei_valid_i / fencei_pc_i  in  1 / XLEN  fence.i retire; restart at fencei_pc_i+4
- br_redirect_i / br_target_i  in  1 / XLEN  mispredict redirect, from exc
- upd_valid_i / upd_pc_i / upd_target_i / upd_taken_i  in  1 / XLEN / XLEN / 1  BTB training, from exc
- req_valid_o  out  1  fetch request valid
- req_addr_o  out  ADDR_W  fetch address = pc_q[ADDR_W-1:0]
- req_ready_i  in  1  icache accepts request
- pc_o  out  XLEN  PC of the current request
- pred_taken_o / pred_target_o  out  1 / XLEN  BTB prediction made for pc_o

## Operation
- State: pc_q, run_q (boot flag), and a BTB array of {valid, tag, target, ctr[1:0]}.
- Next-PC priority: trap_valid_i > fencei_valid_i > br_redirect_i > fire ? (pred_taken_o ? pred_target_o : pc_q+4) : pc_q.
- fire = req_valid_o & req_ready_i.
- Redirects load pc_q even when stall_i=1 or fire=0. Any outstanding unaccepted request is abandoned.
- All adds are XLEN-bit and wrap modulo 2^XLEN.
- req_valid_o = run_q & ~stall_i.
- req_addr_o and pc_o stay stable while req_valid_o & ~req_ready_i. The only exception is a redirect.
- BTB index = pc[IDX+1:2], where IDX = log2(BTB_ENTRIES). Tag = pc[XLEN-1:IDX+2].
- Lookup is combinational on pc_q. pred_taken_o = hit & ctr[1]. pred_target_o = hit ? target : pc_q+4.
- Update (upd_valid_i), taken case:
  - hit: ctr saturating increment, target rewritten.
  - miss: allocate, valid=1, tag/target written, ctr=2'b10.
- Update, not-taken case:
  - hit: ctr saturating decrement.
  - miss: no change.
- fencei_valid_i clears every BTB valid bit. An upd_valid_i in the same cycle is discarded.

## Timing
- Reset (rst_n=0): pc_q=RESET_ADDR, run_q=0, all BTB valid=0.
  - Outputs during reset: req_valid_o=0, pc_o=RESET_ADDR, pred_taken_o=0, pred_target_o=RESET_ADDR+4.
- First rising edge after rst_n release sets run_q. req_valid_o rises one cycle after release.
- Reset asserted mid-request drops req_valid_o immediately (asynchronous).
- Redirect in cycle n gives the new pc_o/req_addr_o in cycle n+1.
- Fire in cycle n gives the advanced PC in cycle n+1. Sustained throughput is one request per cycle.
- A BTB update in cycle n is visible to lookup from cycle n+1. A same-cycle lookup at the same index sees the old entry (no bypass).
- Simultaneous trap + fence.i + branch: trap wins. The fence.i BTB clear still happens.

## Configuration
- YSYX_041514_BTB_EN defined: BTB instantiated as described.
- YSYX_041514_BTB_EN undefined:
  - No BTB storage.
  - pred_taken_o=0 and pred_target_o=pc_q+4 constantly.
  - upd_* inputs ignored.
  - Next-PC is pc_q+4 on fire.

## Structure
- Shared header sysconfig.v holds:
  - default RESET_ADDR
  - XLEN/ADDR_W defaults
  - the YSYX_041514_BTB_EN macro default
- One sub-module, ysyx_041514_btb:
  - ports: lookup pc in; hit/taken/target out; update port; clear input.
  - Parametrised by XLEN and BTB_ENTRIES.
- PC register and next-PC mux stay in ysyx_041514_pc_gen.

## Test plan
- Reset release, req_ready_i=1 constant:
  - req_valid_o=0 for 1 cycle.
  - Then req_addr_o = 0x8000_0000, 0x8000_0004, 0x8000_0008 on successive cycles.
- req_ready_i=0 for 3 cycles at pc 0x8000_0010: req_addr_o holds 0x8000_0010 and req_valid_o stays 1. Advances to 0x8000_0014 one cycle after ready.
- Same-cycle trap_pc_i=0x8000_0100, fencei_pc_i=0x8000_0200, br_target_i=0x8000_0300, stall_i=1: next pc_o = 0x8000_0100.
- fencei_pc_i=0xFFFF_FFFF_FFFF_FFFC: next pc_o = 0x0 (wrap).
- BTB_EN, update pc=0x8000_0020 taken target=0x8000_0080:
  - fetch of 0x8000_0020 gives pred_taken_o=1, next req 0x8000_0080.
  - two not-taken updates give pred_taken_o=0, next req 0x8000_0024.
- BTB trained as above, then fence.i with a concurrent update: all entries miss afterwards and pred_taken_o=0 for 0x8000_0020.

Source files
------------

// File: rtl/ysyx_041514_pc_gen_pkg.sv
// Shared defaults and helpers for the fetch-address generator and its BTB.
// The optional BTB is enabled by defining YSYX_041514_BTB_EN; it is off by default.
package ysyx_041514_pc_gen_pkg;

  localparam int          DEFAULT_XLEN        = 64;
  localparam int          DEFAULT_ADDR_W      = 32;
  localparam int          DEFAULT_BTB_ENTRIES = 8;
  localparam logic [63:0] DEFAULT_RESET_ADDR  = 64'h8000_0000;

  typedef enum logic [1:0] {
    CTR_STRONG_NT = 2'b00,
    CTR_WEAK_NT   = 2'b01,
    CTR_WEAK_T    = 2'b10,
    CTR_STRONG_T  = 2'b11
  } ctr_e;

  // Two-bit saturating counter step toward the observed outcome.
  function automatic logic [1:0] ctr_train(input logic [1:0] c, input logic taken);
    logic [1:0] n;
    n = c;
    if (taken && (c != CTR_STRONG_T)) n = c + 2'd1;
    else if (!taken && (c != CTR_STRONG_NT)) n = c - 2'd1;
    return n;
  endfunction

endpackage

// File: rtl/ysyx_041514_btb.sv
// Direct-mapped branch target buffer with 2-bit counters.
// Lookup is combinational; updates and the bulk clear take effect on the next edge.
module ysyx_041514_btb
  import ysyx_041514_pc_gen_pkg::*;
#(
  parameter int XLEN        = DEFAULT_XLEN,
  parameter int BTB_ENTRIES = DEFAULT_BTB_ENTRIES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lookup_pc_i,
  output logic            hit_o,
  output logic            taken_o,
  output logic [XLEN-1:0] target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_taken_i,
  input  logic            clear_i
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_d    [BTB_ENTRIES];
  logic [XLEN-1:0]        target_q [BTB_ENTRIES];
  logic [XLEN-1:0]        target_d [BTB_ENTRIES];
  logic [1:0]             ctr_q    [BTB_ENTRIES];
  logic [1:0]             ctr_d    [BTB_ENTRIES];

  logic [IDX-1:0]   lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_hit;
  logic             unused_lsbs;

  assign lk_idx      = lookup_pc_i[IDX+1:2];
  assign lk_tag      = lookup_pc_i[XLEN-1:IDX+2];
  assign upd_idx     = upd_pc_i[IDX+1:2];
  assign upd_tag     = upd_pc_i[XLEN-1:IDX+2];
  assign unused_lsbs = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

  assign hit_o    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign taken_o  = hit_o && ctr_q[lk_idx][1];
  assign target_o = target_q[lk_idx];
  assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    // A fence.i flush discards any training arriving in the same cycle.
    if (clear_i) begin
      valid_d = '0;
    end else if (upd_valid_i) begin
      if (upd_taken_i) begin
        target_d[upd_idx] = upd_target_i;
        if (upd_hit) begin
          ctr_d[upd_idx] = ctr_train(ctr_q[upd_idx], 1'b1);
        end else begin
          valid_d[upd_idx] = 1'b1;
          tag_d[upd_idx]   = upd_tag;
          ctr_d[upd_idx]   = CTR_WEAK_T;
        end
      end else if (upd_hit) begin
        ctr_d[upd_idx] = ctr_train(ctr_q[upd_idx], 1'b0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Payload needs no reset: it is only observed through a set valid bit.
  generate
    for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        tag_q[gi]    <= tag_d[gi];
        target_q[gi] <= target_d[gi];
        ctr_q[gi]    <= ctr_d[gi];
      end
    end
  endgenerate

endmodule

// File: rtl/ysyx_041514_pc_gen.sv
// Fetch-address generator: PC register, icache request handshake and next-PC select.
// Define YSYX_041514_BTB_EN to add the branch target buffer predictor.
module ysyx_041514_pc_gen
  import ysyx_041514_pc_gen_pkg::*;
#(
  parameter int              XLEN        = DEFAULT_XLEN,
  parameter int              ADDR_W      = DEFAULT_ADDR_W,
  parameter logic [XLEN-1:0] RESET_ADDR  = XLEN'(DEFAULT_RESET_ADDR),
  parameter int              BTB_ENTRIES = DEFAULT_BTB_ENTRIES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              trap_valid_i,
  input  logic [XLEN-1:0]   trap_pc_i,
  input  logic              fencei_valid_i,
  input  logic [XLEN-1:0]   fencei_pc_i,
  input  logic              br_redirect_i,
  input  logic [XLEN-1:0]   br_target_i,
  input  logic              upd_valid_i,
  input  logic [XLEN-1:0]   upd_pc_i,
  input  logic [XLEN-1:0]   upd_target_i,
  input  logic              upd_taken_i,
  output logic              req_valid_o,
  output logic [ADDR_W-1:0] req_addr_o,
  input  logic              req_ready_i,
  output logic [XLEN-1:0]   pc_o,
  output logic              pred_taken_o,
  output logic [XLEN-1:0]   pred_target_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            run_q, run_d;
  logic [XLEN-1:0] pc_seq;
  logic            fire;

  assign pc_seq      = pc_q + XLEN'(4);
  assign req_valid_o = run_q & ~stall_i;
  assign fire        = req_valid_o & req_ready_i;
  assign req_addr_o  = pc_q[ADDR_W-1:0];
  assign pc_o        = pc_q;

`ifdef YSYX_041514_BTB_EN
  logic            btb_hit;
  logic            btb_taken;
  logic [XLEN-1:0] btb_target;

  ysyx_041514_btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_pc_i  (pc_q),
    .hit_o        (btb_hit),
    .taken_o      (btb_taken),
    .target_o     (btb_target),
    .upd_valid_i  (upd_valid_i),
    .upd_pc_i     (upd_pc_i),
    .upd_target_i (upd_target_i),
    .upd_taken_i  (upd_taken_i),
    .clear_i      (fencei_valid_i)
  );

  assign pred_taken_o  = btb_taken;
  assign pred_target_o = btb_hit ? btb_target : pc_seq;
`else
  logic unused_upd;
  assign unused_upd    = ^{upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i};
  assign pred_taken_o  = 1'b0;
  assign pred_target_o = pc_seq;
`endif

  // Redirects override stall and abandon any request still waiting for ready.
  always_comb begin
    run_d = 1'b1;
    pc_d  = pc_q;
    if (trap_valid_i)        pc_d = trap_pc_i;
    else if (fencei_valid_i) pc_d = fencei_pc_i + XLEN'(4);
    else if (br_redirect_i)  pc_d = br_target_i;
    else if (fire)           pc_d = pred_taken_o ? pred_target_o : pc_seq;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_ADDR;
      run_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      run_q <= run_d;
    end
  end

endmodule

// File: tb/tb_ysyx_041514_pc_gen.sv
// Directed test of the fetch-address generator; BTB cases run when YSYX_041514_BTB_EN is defined.
module tb_ysyx_041514_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        trap_valid_i;
  logic [63:0] trap_pc_i;
  logic        fencei_valid_i;
  logic [63:0] fencei_pc_i;
  logic        br_redirect_i;
  logic [63:0] br_target_i;
  logic        upd_valid_i;
  logic [63:0] upd_pc_i;
  logic [63:0] upd_target_i;
  logic        upd_taken_i;
  logic        req_valid_o;
  logic [31:0] req_addr_o;
  logic        req_ready_i;
  logic [63:0] pc_o;
  logic        pred_taken_o;
  logic [63:0] pred_target_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_041514_pc_gen dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall_i),
    .trap_valid_i   (trap_valid_i),
    .trap_pc_i      (trap_pc_i),
    .fencei_valid_i (fencei_valid_i),
    .fencei_pc_i    (fencei_pc_i),
    .br_redirect_i  (br_redirect_i),
    .br_target_i    (br_target_i),
    .upd_valid_i    (upd_valid_i),
    .upd_pc_i       (upd_pc_i),
    .upd_target_i   (upd_target_i),
    .upd_taken_i    (upd_taken_i),
    .req_valid_o    (req_valid_o),
    .req_addr_o     (req_addr_o),
    .req_ready_i    (req_ready_i),
    .pc_o           (pc_o),
    .pred_taken_o   (pred_taken_o),
    .pred_target_o  (pred_target_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [63:0] tgt);
    br_redirect_i = 1'b1;
    br_target_i   = tgt;
    tick();
    br_redirect_i = 1'b0;
    #1;
  endtask

  task automatic btb_update(input logic [63:0] pc, input logic [63:0] tgt, input logic taken);
    upd_valid_i  = 1'b1;
    upd_pc_i     = pc;
    upd_target_i = tgt;
    upd_taken_i  = taken;
    tick();
    upd_valid_i = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; req_ready_i = 1'b1;
    trap_valid_i = 1'b0; trap_pc_i = '0;
    fencei_valid_i = 1'b0; fencei_pc_i = '0;
    br_redirect_i = 1'b0; br_target_i = '0;
    upd_valid_i = 1'b0; upd_pc_i = '0; upd_target_i = '0; upd_taken_i = 1'b0;

    tick(); tick();
    chk("rst_valid", 64'(req_valid_o), 64'd0);
    chk("rst_pc", pc_o, 64'h8000_0000);
    chk("rst_pred_taken", 64'(pred_taken_o), 64'd0);
    chk("rst_pred_target", pred_target_o, 64'h8000_0004);

    // Release reset: one idle cycle, then back-to-back fetches.
    rst_n = 1'b1;
    #1;
    chk("boot_valid0", 64'(req_valid_o), 64'd0);
    tick();
    chk("boot_valid1", 64'(req_valid_o), 64'd1);
    chk("seq_addr0", 64'(req_addr_o), 64'h8000_0000);
    tick();
    chk("seq_addr1", 64'(req_addr_o), 64'h8000_0004);
    tick();
    chk("seq_addr2", 64'(req_addr_o), 64'h8000_0008);
    tick(); tick();
    chk("seq_addr4", 64'(req_addr_o), 64'h8000_0010);

    // Backpressure: address holds while ready is low.
    req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_addr", 64'(req_addr_o), 64'h8000_0010);
      chk("bp_valid", 64'(req_valid_o), 64'd1);
      tick();
    end
    req_ready_i = 1'b1;
    #1;
    chk("bp_addr_ready", 64'(req_addr_o), 64'h8000_0010);
    tick();
    chk("bp_advance", 64'(req_addr_o), 64'h8000_0014);

    // Stall holds PC and drops the request.
    stall_i = 1'b1;
    #1;
    chk("stall_valid", 64'(req_valid_o), 64'd0);
    tick();
    chk("stall_pc", pc_o, 64'h8000_0014);

    // Simultaneous redirects while stalled: trap wins.
    trap_valid_i = 1'b1; trap_pc_i = 64'h8000_0100;
    fencei_valid_i = 1'b1; fencei_pc_i = 64'h8000_0200;
    br_redirect_i = 1'b1; br_target_i = 64'h8000_0300;
    tick();
    trap_valid_i = 1'b0; fencei_valid_i = 1'b0; br_redirect_i = 1'b0;
    stall_i = 1'b0;
    #1;
    chk("prio_trap", pc_o, 64'h8000_0100);

    // fence.i restart wraps past the top of the address space.
    fencei_valid_i = 1'b1; fencei_pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    fencei_valid_i = 1'b0;
    #1;
    chk("fencei_wrap_pc", pc_o, 64'h0);
    chk("fencei_wrap_addr", 64'(req_addr_o), 64'h0);

    // fence.i beats branch redirect.
    fencei_valid_i = 1'b1; fencei_pc_i = 64'h8000_0040;
    br_redirect_i = 1'b1; br_target_i = 64'h8000_0300;
    tick();
    fencei_valid_i = 1'b0; br_redirect_i = 1'b0;
    #1;
    chk("prio_fencei", pc_o, 64'h8000_0044);

    // Branch redirect while a request is blocked abandons it.
    req_ready_i = 1'b0;
    redirect(64'h8000_0300);
    chk("br_redirect", pc_o, 64'h8000_0300);
    req_ready_i = 1'b1;
    tick();
    chk("br_then_seq", pc_o, 64'h8000_0304);

    // Asynchronous reset drops the request without waiting for an edge.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(req_valid_o), 64'd0);
    chk("async_rst_pc", pc_o, 64'h8000_0000);
    tick();
    rst_n = 1'b1;
    stall_i = 1'b1;
    tick();

`ifdef YSYX_041514_BTB_EN
    btb_update(64'h8000_0020, 64'h8000_0080, 1'b1);
    redirect(64'h8000_0020);
    stall_i = 1'b0;
    #1;
    chk("btb_taken", 64'(pred_taken_o), 64'd1);
    chk("btb_target", pred_target_o, 64'h8000_0080);
    tick();
    chk("btb_follow", pc_o, 64'h8000_0080);

    stall_i = 1'b1;
    btb_update(64'h8000_0020, 64'h8000_0080, 1'b0);
    btb_update(64'h8000_0020, 64'h8000_0080, 1'b0);
    redirect(64'h8000_0020);
    stall_i = 1'b0;
    #1;
    chk("btb_nt_taken", 64'(pred_taken_o), 64'd0);
    tick();
    chk("btb_nt_seq", pc_o, 64'h8000_0024);

    // Retrain to taken, then flush with a concurrent (discarded) update.
    stall_i = 1'b1;
    btb_update(64'h8000_0020, 64'h8000_0080, 1'b1);
    btb_update(64'h8000_0020, 64'h8000_0080, 1'b1);
    redirect(64'h8000_0020);
    chk("btb_retrain", 64'(pred_taken_o), 64'd1);
    fencei_valid_i = 1'b1; fencei_pc_i = 64'h8000_001C;
    upd_valid_i = 1'b1; upd_pc_i = 64'h8000_0040;
    upd_target_i = 64'h8000_0100; upd_taken_i = 1'b1;
    tick();
    fencei_valid_i = 1'b0; upd_valid_i = 1'b0;
    #1;
    chk("flush_pc", pc_o, 64'h8000_0020);
    chk("flush_taken", 64'(pred_taken_o), 64'd0);
    chk("flush_target", pred_target_o, 64'h8000_0024);
    redirect(64'h8000_0040);
    chk("flush_upd_dropped", 64'(pred_taken_o), 64'd0);
`else
    btb_update(64'h8000_0020, 64'h8000_0080, 1'b1);
    redirect(64'h8000_0020);
    stall_i = 1'b0;
    #1;
    chk("nobtb_taken", 64'(pred_taken_o), 64'd0);
    chk("nobtb_target", pred_target_o, 64'h8000_0024);
    tick();
    chk("nobtb_seq", pc_o, 64'h8000_0024);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
